// File: rtl/mmu_pkg.sv
// Shared opcodes, exception codes, TLB entry layout and FSM states for the MMU responder.
// Latency: none (types and constants only).
// Backpressure: n/a.
package mmu_pkg;

    // Memory operation opcodes carried on mmu_opt.
    localparam int MEM_OPT_WIDTH = 3;
    localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_NONE = 3'd0;
    localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_LB   = 3'd1;
    localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_LBU  = 3'd2;
    localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_LW   = 3'd3;
    localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_SB   = 3'd4;
    localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_SW   = 3'd5;

    // Exception codes; MIPS numbering for the faults, an unused code for "no fault".
    localparam int EXC_CODE_WIDTH = 5;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_NONE = 5'h1F;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_MOD  = 5'h01;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_TLBL = 5'h02;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_TLBS = 5'h03;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_ADEL = 5'h04;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_ADES = 5'h05;

    // TLB geometry: entry is {VPN2, PFN1, D1, V1, PFN0, D0, V0}.
    localparam int TLB_INDEX_WIDTH        = 4;
    localparam int TLB_ENTRY_WIDTH        = 19 + 20 + 1 + 1 + 20 + 1 + 1;
    localparam int TLB_WRITE_STRUCT_WIDTH = 1 + TLB_INDEX_WIDTH + TLB_ENTRY_WIDTH;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [19:0] pfn1;
        logic        d1;
        logic        v1;
        logic [19:0] pfn0;
        logic        d0;
        logic        v0;
    } tlb_entry_t;

    typedef struct packed {
        logic                       en;
        logic [TLB_INDEX_WIDTH-1:0] idx;
        tlb_entry_t                 entry;
    } tlb_write_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XLATE = 2'd1,
        ST_BUS   = 2'd2
    } state_e;

    function automatic logic op_is_store(input logic [MEM_OPT_WIDTH-1:0] op);
        return (op == MEM_OPT_SB) || (op == MEM_OPT_SW);
    endfunction

    function automatic logic op_is_word(input logic [MEM_OPT_WIDTH-1:0] op);
        return (op == MEM_OPT_LW) || (op == MEM_OPT_SW);
    endfunction

endpackage

// File: rtl/mmu_tlb_lookup.sv
// Fully associative TLB: entry array, write port, combinational VPN2 match with lowest-index priority.
// Latency: writes visible from the posedge after the strobe; lookup is combinational on current contents.
// Backpressure: none; a write is taken on any posedge with wr_en_i high.
module mmu_tlb_lookup
    import mmu_pkg::*;
#(
    parameter int TLB_NR_ENTRY = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en_i,
    input  logic [TLB_INDEX_WIDTH-1:0] wr_idx_i,
    input  tlb_entry_t                 wr_entry_i,
    input  logic [18:0]                vpn2_i,
    input  logic                       odd_i,
    output logic                       hit_o,
    output logic [19:0]                pfn_o,
    output logic                       v_o,
    output logic                       d_o
);

    tlb_entry_t entry_q [TLB_NR_ENTRY];

    // Entry array; reset clears every entry so all pages start invalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TLB_NR_ENTRY; i++) begin
                entry_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            entry_q[wr_idx_i] <= wr_entry_i;
        end
    end

    // Match on VPN2 only; scanning downwards lets the lowest matching index overwrite the result.
    always_comb begin
        hit_o = 1'b0;
        pfn_o = '0;
        v_o   = 1'b0;
        d_o   = 1'b0;
        for (int i = TLB_NR_ENTRY - 1; i >= 0; i--) begin
            if (entry_q[i].vpn2 == vpn2_i) begin
                hit_o = 1'b1;
                pfn_o = odd_i ? entry_q[i].pfn1 : entry_q[i].pfn0;
                v_o   = odd_i ? entry_q[i].v1   : entry_q[i].v0;
                d_o   = odd_i ? entry_q[i].d1   : entry_q[i].d0;
            end
        end
    end

endmodule

// File: rtl/mmu.sv
// MMU responder: latches an op pulse, translates (kseg0/1 window or TLB when MMU_TLB_EN is defined), runs one req/ack bus cycle.
// Latency: accept -> busy low in 1 cycle on a fault, 2+k cycles on success (k = cycles of ack wait).
// Backpressure: mmu_busy high while a request is in flight; op pulses seen while busy are dropped; phy_req held until phy_ack.
module mmu
    import mmu_pkg::*;
#(
    parameter int TLB_NR_ENTRY = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [TLB_WRITE_STRUCT_WIDTH-1:0] tlb_write_struct,
    input  logic [MEM_OPT_WIDTH-1:0]          mmu_opt,
    input  logic [31:0]                       mmu_addr,
    input  logic [31:0]                       mmu_data_out,
    output logic [31:0]                       mmu_data_in,
    output logic [EXC_CODE_WIDTH-1:0]         mmu_exc_code,
    output logic                              mmu_busy,
    output logic [31:0]                       phy_addr,
    output logic [31:0]                       phy_wdata,
    output logic [3:0]                        phy_be,
    output logic                              phy_we,
    output logic                              phy_req,
    input  logic [31:0]                       phy_rdata,
    input  logic                              phy_ack
);

    state_e                      state_q, state_d;
    logic [MEM_OPT_WIDTH-1:0]    op_q, op_d;
    logic [31:0]                 addr_q, addr_d;
    logic [31:0]                 wdat_q, wdat_d;
    logic                        busy_q, busy_d;
    logic [EXC_CODE_WIDTH-1:0]   exc_q, exc_d;
    logic [31:0]                 rdat_q, rdat_d;
    logic                        req_q, req_d;
    logic [31:0]                 paddr_q, paddr_d;
    logic [31:0]                 pwdat_q, pwdat_d;
    logic [3:0]                  be_q, be_d;
    logic                        we_q, we_d;

    // Translation source for the latched address.
    logic        unmapped;
    logic        tlb_hit;
    logic [19:0] tlb_pfn;
    logic        tlb_v;
    logic        tlb_d;

`ifdef MMU_TLB_EN
    tlb_write_t tlb_wr;
    assign tlb_wr = tlb_write_t'(tlb_write_struct);

    mmu_tlb_lookup #(
        .TLB_NR_ENTRY (TLB_NR_ENTRY)
    ) u_tlb (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (tlb_wr.en),
        .wr_idx_i   (tlb_wr.idx),
        .wr_entry_i (tlb_wr.entry),
        .vpn2_i     (addr_q[31:13]),
        .odd_i      (addr_q[12]),
        .hit_o      (tlb_hit),
        .pfn_o      (tlb_pfn),
        .v_o        (tlb_v),
        .d_o        (tlb_d)
    );

    // kseg0/kseg1 (0x8000_0000..0xBFFF_FFFF) bypass the TLB.
    assign unmapped = (addr_q[31:30] == 2'b10);
`else
    // Without a TLB every address folds into the low 512 MB window and TLB writes are dropped.
    logic unused_cfg;
    assign unmapped   = 1'b1;
    assign tlb_hit    = 1'b0;
    assign tlb_pfn    = '0;
    assign tlb_v      = 1'b0;
    assign tlb_d      = 1'b0;
    assign unused_cfg = (^tlb_write_struct) ^ (^addr_q[31:29]) ^ (TLB_NR_ENTRY == 0);
`endif

    logic                      st;
    logic                      wd;
    logic                      xl_fault;
    logic [EXC_CODE_WIDTH-1:0] xl_exc;
    logic [31:0]               xl_pa;
    logic [3:0]                xl_be;
    logic [31:0]               xl_wdat;
    logic [7:0]                ld_byte;
    logic [31:0]               ld_data;

    assign st = op_is_store(op_q);
    assign wd = op_is_word(op_q);

    // Fault classification and physical address for the latched request.
    always_comb begin
        xl_fault = 1'b0;
        xl_exc   = EC_NONE;
        xl_pa    = '0;
        if (wd && (addr_q[1:0] != 2'b00)) begin
            xl_fault = 1'b1;
            xl_exc   = st ? EC_ADES : EC_ADEL;
        end else if (unmapped) begin
            xl_pa = {3'b000, addr_q[28:2], 2'b00};
        end else if (!tlb_hit || !tlb_v) begin
            xl_fault = 1'b1;
            xl_exc   = st ? EC_TLBS : EC_TLBL;
        end else if (st && !tlb_d) begin
            xl_fault = 1'b1;
            xl_exc   = EC_MOD;
        end else begin
            xl_pa = {tlb_pfn, addr_q[11:2], 2'b00};
        end
    end

    // Little-endian lane selection for stores and load extraction.
    always_comb begin
        xl_be   = wd ? 4'b1111 : (4'b0001 << addr_q[1:0]);
        xl_wdat = wd ? wdat_q : {4{wdat_q[7:0]}};
        case (addr_q[1:0])
            2'd0:    ld_byte = phy_rdata[7:0];
            2'd1:    ld_byte = phy_rdata[15:8];
            2'd2:    ld_byte = phy_rdata[23:16];
            default: ld_byte = phy_rdata[31:24];
        endcase
        if (op_q == MEM_OPT_LB) begin
            ld_data = {{24{ld_byte[7]}}, ld_byte};
        end else if (op_q == MEM_OPT_LBU) begin
            ld_data = {24'h0, ld_byte};
        end else begin
            ld_data = phy_rdata;
        end
    end

    // Next state: accept in IDLE, resolve in XLATE, wait for ack in BUS.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        busy_d  = busy_q;
        exc_d   = exc_q;
        rdat_d  = rdat_q;
        req_d   = req_q;
        paddr_d = paddr_q;
        pwdat_d = pwdat_q;
        be_d    = be_q;
        we_d    = we_q;
        unique case (state_q)
            ST_IDLE: begin
                if (mmu_opt != MEM_OPT_NONE) begin
                    op_d    = mmu_opt;
                    addr_d  = mmu_addr;
                    wdat_d  = mmu_data_out;
                    busy_d  = 1'b1;
                    exc_d   = EC_NONE;
                    state_d = ST_XLATE;
                end
            end
            ST_XLATE: begin
                if (xl_fault) begin
                    exc_d   = xl_exc;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    req_d   = 1'b1;
                    paddr_d = xl_pa;
                    be_d    = xl_be;
                    we_d    = st;
                    pwdat_d = xl_wdat;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                if (phy_ack) begin
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                    if (!st) begin
                        rdat_d = ld_data;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; async reset abandons any bus cycle immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            op_q    <= MEM_OPT_NONE;
            addr_q  <= '0;
            wdat_q  <= '0;
            busy_q  <= 1'b0;
            exc_q   <= EC_NONE;
            rdat_q  <= '0;
            req_q   <= 1'b0;
            paddr_q <= '0;
            pwdat_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            busy_q  <= busy_d;
            exc_q   <= exc_d;
            rdat_q  <= rdat_d;
            req_q   <= req_d;
            paddr_q <= paddr_d;
            pwdat_q <= pwdat_d;
            be_q    <= be_d;
            we_q    <= we_d;
        end
    end

    assign mmu_busy     = busy_q;
    assign mmu_exc_code = exc_q;
    assign mmu_data_in  = rdat_q;
    assign phy_req      = req_q;
    assign phy_addr     = paddr_q;
    assign phy_wdata    = pwdat_q;
    assign phy_be       = be_q;
    assign phy_we       = we_q;

endmodule

// File: tb/tb_mmu.sv
// Bench for mmu: directed cases followed by random ops against a behavioural memory/TLB model.
// Latency: drives and samples on negedges; bus acks after a chosen wait.
// Backpressure: every wait is bounded by a cycle budget.
module tb_mmu;
    import mmu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    tlb_write_t  tlb_w;
    logic [2:0]  mmu_opt;
    logic [31:0] mmu_addr, mmu_data_out, mmu_data_in;
    logic [4:0]  mmu_exc_code;
    logic        mmu_busy;
    logic [31:0] phy_addr, phy_wdata, phy_rdata;
    logic [3:0]  phy_be;
    logic        phy_we, phy_req, phy_ack;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: the TLB as plain arrays and the last load result.
    logic [18:0] m_vpn2 [16];
    logic [19:0] m_pfn  [16][2];
    logic        m_v    [16][2];
    logic        m_d    [16][2];
    logic [31:0] m_data_in;

    always #5 clk = ~clk;

    mmu dut (
        .clk              (clk),
        .rst              (rst),
        .tlb_write_struct (tlb_w),
        .mmu_opt          (mmu_opt),
        .mmu_addr         (mmu_addr),
        .mmu_data_out     (mmu_data_out),
        .mmu_data_in      (mmu_data_in),
        .mmu_exc_code     (mmu_exc_code),
        .mmu_busy         (mmu_busy),
        .phy_addr         (phy_addr),
        .phy_wdata        (phy_wdata),
        .phy_be           (phy_be),
        .phy_we           (phy_we),
        .phy_req          (phy_req),
        .phy_rdata        (phy_rdata),
        .phy_ack          (phy_ack)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_vpn2[i] = '0;
            for (int j = 0; j < 2; j++) begin
                m_pfn[i][j] = '0;
                m_v[i][j]   = 1'b0;
                m_d[i][j]   = 1'b0;
            end
        end
        m_data_in = '0;
    endtask

    // Expected outcome of one request, from the address map, alignment rules and TLB contents.
    function automatic void model(input logic [2:0] op, input logic [31:0] va, input logic [31:0] wd,
                                  input logic [31:0] rd, output bit fault, output logic [4:0] ec,
                                  output logic [31:0] pa, output logic [3:0] be,
                                  output logic [31:0] pwd, output logic [31:0] ld);
        bit store, word, mapped;
        int lane, found, pg;
        logic [31:0] b;
        store = (op == MEM_OPT_SW) || (op == MEM_OPT_SB);
        word  = (op == MEM_OPT_SW) || (op == MEM_OPT_LW);
        lane  = int'(va[1:0]);
        fault = 1'b0;
        ec    = EC_NONE;
        pa    = '0;
        if (word && lane != 0) begin
            fault = 1'b1;
            ec    = store ? EC_ADES : EC_ADEL;
        end else begin
            mapped = 1'b0;
`ifdef MMU_TLB_EN
            if (!(va >= 32'h8000_0000 && va < 32'hC000_0000)) mapped = 1'b1;
`endif
            if (!mapped) begin
                pa = va % 32'h2000_0000;
            end else begin
                found = -1;
                pg    = int'(va[12]);
                for (int i = 15; i >= 0; i--) begin
                    if (32'(m_vpn2[i]) == (va >> 13)) found = i;
                end
                if (found < 0 || !m_v[found][pg]) begin
                    fault = 1'b1;
                    ec    = store ? EC_TLBS : EC_TLBL;
                end else if (store && !m_d[found][pg]) begin
                    fault = 1'b1;
                    ec    = EC_MOD;
                end else begin
                    pa = 32'(m_pfn[found][pg]) * 32'd4096 + (va % 32'd4096);
                end
            end
            pa = pa - (pa % 32'd4);
        end
        be  = word ? 4'hF : 4'(1 << lane);
        pwd = word ? wd : (wd & 32'hFF) * 32'h0101_0101;
        b   = (rd >> (8 * lane)) & 32'hFF;
        if (op == MEM_OPT_LW)                   ld = rd;
        else if (op == MEM_OPT_LB && b >= 128)  ld = b | 32'hFFFF_FF00;
        else                                    ld = b;
    endfunction

    task automatic tlb_write(input int idx, input logic [18:0] vpn2, input logic [19:0] pfn1,
                             input logic d1, input logic v1, input logic [19:0] pfn0,
                             input logic d0, input logic v0);
        @(negedge clk);
        tlb_w.en          = 1'b1;
        tlb_w.idx         = 4'(idx);
        tlb_w.entry.vpn2  = vpn2;
        tlb_w.entry.pfn1  = pfn1;
        tlb_w.entry.d1    = d1;
        tlb_w.entry.v1    = v1;
        tlb_w.entry.pfn0  = pfn0;
        tlb_w.entry.d0    = d0;
        tlb_w.entry.v0    = v0;
        @(negedge clk);
        tlb_w.en = 1'b0;
        m_vpn2[idx]   = vpn2;
        m_pfn[idx][1] = pfn1;
        m_d[idx][1]   = d1;
        m_v[idx][1]   = v1;
        m_pfn[idx][0] = pfn0;
        m_d[idx][0]   = d0;
        m_v[idx][0]   = v0;
    endtask

    // One request: k = BUS cycles with ack low before the ack; poke = stray op pulse while busy.
    task automatic run_op(input logic [2:0] op, input logic [31:0] va, input logic [31:0] wd,
                          input int k, input logic [31:0] rd, input bit poke);
        bit fault, store;
        logic [4:0] ec;
        logic [31:0] pa, pwd, ld;
        logic [3:0] be;
        int busy_cyc, req_cyc;
        model(op, va, wd, rd, fault, ec, pa, be, pwd, ld);
        store = (op == MEM_OPT_SW) || (op == MEM_OPT_SB);
        @(negedge clk);
        mmu_opt      = op;
        mmu_addr     = va;
        mmu_data_out = wd;
        @(negedge clk);
        mmu_opt  = MEM_OPT_NONE;
        busy_cyc = 0;
        req_cyc  = 0;
        check("busy_after_accept", 32'(mmu_busy), 32'd1);
        while (mmu_busy === 1'b1 && busy_cyc < 40) begin
            busy_cyc++;
            phy_ack   = 1'b0;
            phy_rdata = ~rd;
            mmu_opt   = MEM_OPT_NONE;
            if (poke && busy_cyc == 1) begin
                mmu_opt  = MEM_OPT_SW;
                mmu_addr = 32'h8000_0100;
            end
            if (phy_req === 1'b1) begin
                check("phy_addr", phy_addr, pa);
                check("phy_be", 32'(phy_be), 32'(be));
                check("phy_we", 32'(phy_we), 32'(store));
                if (store) check("phy_wdata", phy_wdata, pwd);
                if (req_cyc == k) begin
                    phy_ack   = 1'b1;
                    phy_rdata = rd;
                end
                req_cyc++;
            end
            @(negedge clk);
        end
        phy_ack = 1'b0;
        mmu_opt = MEM_OPT_NONE;
        if (!fault && !store) m_data_in = ld;
        check("busy_cycles", 32'(busy_cyc), fault ? 32'd1 : 32'(2 + k));
        check("req_cycles", 32'(req_cyc), fault ? 32'd0 : 32'(k + 1));
        check("exc_code", 32'(mmu_exc_code), 32'(ec));
        check("data_in", mmu_data_in, m_data_in);
        check("req_after", 32'(phy_req), 32'd0);
    endtask

    initial begin
        logic [18:0] pool [4];
        logic [2:0]  ops  [5];
        logic [2:0]  op;
        logic [31:0] va;
        int          sel;
        pool[0] = 19'h00200; pool[1] = 19'h00201; pool[2] = 19'h12345; pool[3] = 19'h60000;
        ops[0] = MEM_OPT_LB; ops[1] = MEM_OPT_LBU; ops[2] = MEM_OPT_LW;
        ops[3] = MEM_OPT_SB; ops[4] = MEM_OPT_SW;

        rst          = 1'b1;
        tlb_w        = '0;
        mmu_opt      = MEM_OPT_NONE;
        mmu_addr     = '0;
        mmu_data_out = '0;
        phy_rdata    = '0;
        phy_ack      = 1'b0;
        model_reset();
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(mmu_busy), 32'd0);
        check("rst_exc", 32'(mmu_exc_code), 32'(EC_NONE));
        check("rst_data_in", mmu_data_in, 32'd0);
        check("rst_req", 32'(phy_req), 32'd0);
        check("rst_we", 32'(phy_we), 32'd0);
        check("rst_be", 32'(phy_be), 32'd0);
        check("rst_addr", phy_addr, 32'd0);
        check("rst_wdata", phy_wdata, 32'd0);
        rst = 1'b1;

        // Directed cases.
        run_op(MEM_OPT_LW,  32'h8000_1000, 32'h0, 2, 32'hDEAD_BEEF, 1'b0);
        run_op(MEM_OPT_LB,  32'h8000_0003, 32'h0, 0, 32'h8012_3456, 1'b0);
        run_op(MEM_OPT_LBU, 32'h8000_0003, 32'h0, 1, 32'h8012_3456, 1'b0);
        run_op(MEM_OPT_SW,  32'h0040_0000, 32'h1234_5678, 0, 32'h0, 1'b0);
        tlb_write(2, 19'h00200, 20'h0, 1'b0, 1'b0, 20'h00123, 1'b0, 1'b1);
        run_op(MEM_OPT_SW,  32'h0040_0010, 32'h1111_2222, 0, 32'h0, 1'b0);
        run_op(MEM_OPT_LW,  32'h0040_0010, 32'h0, 1, 32'hCAFE_F00D, 1'b0);
        run_op(MEM_OPT_SW,  32'h8000_0002, 32'h5555_5555, 0, 32'h0, 1'b0);
        run_op(MEM_OPT_SB,  32'h8000_0002, 32'h0000_00AB, 0, 32'h0, 1'b0);
        run_op(MEM_OPT_LW,  32'h8000_0005, 32'h0, 0, 32'h0, 1'b0);
        tlb_write(9, 19'h12345, 20'h0, 1'b0, 1'b0, 20'hAAAAA, 1'b1, 1'b1);
        tlb_write(5, 19'h12345, 20'h0, 1'b0, 1'b0, 20'h55555, 1'b1, 1'b1);
        run_op(MEM_OPT_LW,  32'h2468_A004, 32'h0, 0, 32'h0BAD_CAFE, 1'b1);

        // Reset in the middle of a bus cycle.
        @(negedge clk);
        mmu_opt  = MEM_OPT_LW;
        mmu_addr = 32'h8000_2000;
        @(negedge clk);
        mmu_opt = MEM_OPT_NONE;
        @(negedge clk);
        check("midbus_req", 32'(phy_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("midbus_rst_req", 32'(phy_req), 32'd0);
        check("midbus_rst_busy", 32'(mmu_busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        check("midbus_rst_data_in", mmu_data_in, 32'd0);
        run_op(MEM_OPT_LW, 32'h8000_0040, 32'h0, 0, 32'h7654_3210, 1'b0);

        // Random mix of TLB updates and requests.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                tlb_write(int'($urandom_range(0, 15)), pool[$urandom_range(0, 3)],
                          20'($urandom), 1'($urandom), 1'($urandom),
                          20'($urandom), 1'($urandom), 1'($urandom));
            end
            op  = ops[$urandom_range(0, 4)];
            sel = int'($urandom_range(0, 3));
            if (sel == 0) va = 32'h8000_0000 | ($urandom & 32'h3FFF_FFFF);
            else if (sel == 3) va = $urandom;
            else va = {pool[$urandom_range(0, 3)], 13'($urandom)};
            if ($urandom_range(0, 3) != 0 && (op == MEM_OPT_LW || op == MEM_OPT_SW)) va[1:0] = 2'b00;
            run_op(op, va, $urandom, int'($urandom_range(0, 3)), $urandom, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
